// File: rtl/pipe_mem_if.sv
// EX->MEM handshake, SRAM read data and MEM outputs toward WB/ID.
interface pipe_mem_if;
  logic        from_valid;
  logic        to_allowin;
  logic        from_allowin;
  logic        to_valid;
  logic [31:0] from_pc;
  logic [31:0] alu_result_EX;
  logic        rf_we_EX;
  logic [4:0]  rf_waddr_EX;
  logic        res_from_mem_EX;
  logic [2:0]  mem_op_EX;
  logic [31:0] data_sram_rdata;
  logic [31:0] PC;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_we;
  logic        fwd_from_mem;

  modport slave (
    input  from_valid, from_allowin, from_pc, alu_result_EX, rf_we_EX,
           rf_waddr_EX, res_from_mem_EX, mem_op_EX, data_sram_rdata,
    output to_allowin, to_valid, PC, rf_we, rf_waddr, rf_wdata,
           fwd_we, fwd_from_mem
  );

  modport master (
    output from_valid, from_allowin, from_pc, alu_result_EX, rf_we_EX,
           rf_waddr_EX, res_from_mem_EX, mem_op_EX, data_sram_rdata,
    input  to_allowin, to_valid, PC, rf_we, rf_waddr, rf_wdata,
           fwd_we, fwd_from_mem
  );
endinterface

// File: rtl/pipe_mem.sv
// MEM stage: latches EX payload, captures/holds SRAM read data, and
// produces the load-extended write-back value plus ID forwarding info.
module pipe_mem (
  input logic       clk,
  input logic       reset,
  pipe_mem_if.slave bus
);
  logic        valid, first, ready_go, allowin, accept;
  logic [31:0] pc_r, alu_result, rdata_hold, load_word, load_ext;
  logic        rf_we_r, res_from_mem;
  logic [4:0]  rf_waddr_r;
  logic [2:0]  mem_op;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ready_go = valid;
  assign allowin  = !valid | (ready_go & bus.from_allowin);
  assign accept   = bus.from_valid & allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid        <= 1'b0;
      first        <= 1'b0;
      rdata_hold   <= '0;
      pc_r         <= '0;
      alu_result   <= '0;
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= '0;
      res_from_mem <= 1'b0;
      mem_op       <= '0;
    end else begin
      if (allowin) valid <= bus.from_valid;
      first <= accept;
      // SRAM data is only meaningful in the first cycle; keep it for stalls
      if (valid & first) rdata_hold <= bus.data_sram_rdata;
      if (accept) begin
        pc_r         <= bus.from_pc;
        alu_result   <= bus.alu_result_EX;
        rf_we_r      <= bus.rf_we_EX;
        rf_waddr_r   <= bus.rf_waddr_EX;
        res_from_mem <= bus.res_from_mem_EX;
        mem_op       <= bus.mem_op_EX;
      end
    end
  end

  assign load_word = first ? bus.data_sram_rdata : rdata_hold;

  always_comb begin
    ld_byte = load_word[7:0];
    case (alu_result[1:0])
      2'd1:    ld_byte = load_word[15:8];
      2'd2:    ld_byte = load_word[23:16];
      2'd3:    ld_byte = load_word[31:24];
      default: ld_byte = load_word[7:0];
    endcase
    // halfword lane ignores addr[0]; misalignment is not flagged here
    ld_half = alu_result[1] ? load_word[31:16] : load_word[15:0];
    case (mem_op)
      3'b001:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b011:  load_ext = {24'b0, ld_byte};
      3'b100:  load_ext = {16'b0, ld_half};
      default: load_ext = load_word;
    endcase
  end

  assign bus.to_allowin   = allowin;
  assign bus.to_valid     = valid & ready_go;
  assign bus.PC           = pc_r;
  assign bus.rf_we        = rf_we_r;
  assign bus.rf_waddr     = rf_waddr_r;
  assign bus.rf_wdata     = res_from_mem ? load_ext : alu_result;
  assign bus.fwd_we       = valid & rf_we_r;
  assign bus.fwd_from_mem = valid & res_from_mem;
endmodule

// File: tb/tb_pipe_mem.sv
// Directed + random bench for pipe_mem against an instruction-level model.
module tb_pipe_mem;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic        we;
    logic [4:0]  waddr;
    logic        rfm;
    logic [2:0]  op;
  } ins_t;

  logic clk = 1'b0;
  logic reset;
  pipe_mem_if b ();
  pipe_mem dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   xfers    = 0;
  int   x0;
  // model: the instruction in MEM, whether this is its first cycle, its word
  logic        m_valid, m_first;
  ins_t        m_ins;
  logic [31:0] m_word;
  logic [31:0] obs_wd, obs_pc;
  logic        obs_alw, obs_tv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic [31:0] pc, input logic [31:0] alu,
                              input logic we, input logic rfm, input logic [2:0] op);
    ins_t i;
    i.pc = pc; i.alu = alu; i.we = we; i.waddr = pc[6:2]; i.rfm = rfm; i.op = op;
    return i;
  endfunction

  function automatic logic [31:0] ref_wdata(input ins_t i, input logic [31:0] w);
    logic [31:0] by, hw;
    by = (w >> (32'(i.alu[1:0]) * 8)) & 32'hFF;
    hw = i.alu[1] ? (w >> 16) : (w & 32'hFFFF);
    if (!i.rfm) return i.alu;
    case (i.op)
      3'd1:    return (by >= 128) ? by + 32'hFFFFFF00 : by;
      3'd2:    return (hw >= 32768) ? hw + 32'hFFFF0000 : hw;
      3'd3:    return by;
      3'd4:    return hw;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_first = 1'b0; m_ins = '0; m_word = '0;
  endtask

  // One cycle: drive inputs, check outputs against the model, clock, update.
  task automatic cycle(input logic fv, input ins_t ins, input logic fa, input logic [31:0] rd);
    logic acc;
    b.from_valid = fv; b.from_pc = ins.pc; b.alu_result_EX = ins.alu;
    b.rf_we_EX = ins.we; b.rf_waddr_EX = ins.waddr; b.res_from_mem_EX = ins.rfm;
    b.mem_op_EX = ins.op; b.from_allowin = fa; b.data_sram_rdata = rd;
    #1;
    if (m_first) m_word = rd;
    obs_wd = b.rf_wdata; obs_pc = b.PC; obs_alw = b.to_allowin; obs_tv = b.to_valid;
    chk("to_valid", 32'(b.to_valid), 32'(m_valid));
    chk("to_allowin", 32'(b.to_allowin), 32'(!m_valid || fa));
    chk("fwd_we", 32'(b.fwd_we), 32'(m_valid && m_ins.we));
    chk("fwd_from_mem", 32'(b.fwd_from_mem), 32'(m_valid && m_ins.rfm));
    chk("rf_wdata", b.rf_wdata, ref_wdata(m_ins, m_word));
    chk("PC", b.PC, m_ins.pc);
    chk("rf_waddr", 32'(b.rf_waddr), 32'(m_ins.waddr));
    if (b.to_valid && fa) xfers++;
    acc = fv && (!m_valid || fa);
    @(posedge clk);
    if (!m_valid || fa) m_valid = fv;
    m_first = acc;
    if (acc) m_ins = ins;
    #1;
  endtask

  ins_t nop, ri;

  initial begin
    nop = '0;
    b.from_valid = 0; b.from_pc = 0; b.alu_result_EX = 0; b.rf_we_EX = 0;
    b.rf_waddr_EX = 0; b.res_from_mem_EX = 0; b.mem_op_EX = 0; b.from_allowin = 0;
    b.data_sram_rdata = 0;
    reset = 1'b1;
    model_reset();
    #2;
    chk("rst_to_valid", 32'(b.to_valid), 0);
    chk("rst_to_allowin", 32'(b.to_allowin), 1);
    chk("rst_fwd_we", 32'(b.fwd_we), 0);
    chk("rst_fwd_from_mem", 32'(b.fwd_from_mem), 0);
    chk("rst_rf_wdata", b.rf_wdata, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // ld.w 0x100, then ld.b/ld.bu 0x103, ld.h/ld.hu 0x102 back to back
    cycle(1, mk(32'h1000, 32'h100, 1, 1, 3'd0), 1, 32'h0);
    cycle(1, mk(32'h1004, 32'h103, 1, 1, 3'd1), 1, 32'hDEADBEEF);
    chk("ldw", obs_wd, 32'hDEADBEEF);
    chk("ldw_tv", 32'(obs_tv), 1);
    cycle(1, mk(32'h1008, 32'h103, 1, 1, 3'd3), 1, 32'h80FF1234);
    chk("ldb", obs_wd, 32'hFFFFFF80);
    cycle(1, mk(32'h100C, 32'h102, 1, 1, 3'd2), 1, 32'h80FF1234);
    chk("ldbu", obs_wd, 32'h00000080);
    cycle(1, mk(32'h1010, 32'h102, 1, 1, 3'd4), 1, 32'h80FF1234);
    chk("ldh", obs_wd, 32'hFFFF80FF);
    cycle(1, mk(32'h1014, 32'h005, 1, 0, 3'd0), 1, 32'h80FF1234);
    chk("ldhu", obs_wd, 32'h000080FF);
    // ALU op then ld.w back to back
    cycle(1, mk(32'h1018, 32'h200, 1, 1, 3'd0), 1, 32'h33333333);
    chk("alu_b2b", obs_wd, 32'h5);
    cycle(0, nop, 1, 32'h0000000A);
    chk("ldw_b2b", obs_wd, 32'hA);

    // WB stall: first-cycle word must survive later SRAM changes
    cycle(1, mk(32'h1020, 32'h300, 1, 1, 3'd0), 1, 32'h0);
    x0 = xfers;
    cycle(0, nop, 0, 32'h11111111);
    chk("stall0_wd", obs_wd, 32'h11111111);
    chk("stall0_alw", 32'(obs_alw), 0);
    for (int k = 1; k < 3; k++) begin
      cycle(0, nop, 0, 32'h22222222);
      chk("stall_wd", obs_wd, 32'h11111111);
      chk("stall_alw", 32'(obs_alw), 0);
    end
    cycle(0, nop, 1, 32'h22222222);
    cycle(0, nop, 1, 32'h22222222);
    chk("stall_xfers", 32'(xfers - x0), 1);

    // bubble: from_valid 1,0,1
    cycle(1, mk(32'h2000, 32'h7, 1, 0, 3'd0), 1, 32'h0);
    cycle(0, mk(32'h2004, 32'h8, 1, 0, 3'd0), 1, 32'h0);
    chk("pre_bubble_tv", 32'(obs_tv), 1);
    cycle(1, mk(32'h2008, 32'h9, 1, 0, 3'd0), 1, 32'h0);
    chk("bubble_tv", 32'(obs_tv), 0);
    chk("bubble_pc", obs_pc, 32'h2000);
    cycle(0, nop, 1, 32'h0);
    chk("post_bubble_pc", obs_pc, 32'h2008);

    // reset mid-stall with a load held
    cycle(1, mk(32'h3000, 32'h400, 1, 1, 3'd0), 1, 32'h0);
    cycle(0, nop, 0, 32'h55555555);
    cycle(0, nop, 0, 32'h66666666);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_to_valid", 32'(b.to_valid), 0);
    chk("mrst_fwd_we", 32'(b.fwd_we), 0);
    chk("mrst_fwd_from_mem", 32'(b.fwd_from_mem), 0);
    chk("mrst_to_allowin", 32'(b.to_allowin), 1);
    chk("mrst_rf_wdata", b.rf_wdata, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1, mk(32'h3100, 32'h101, 1, 1, 3'd3), 1, 32'h0);
    cycle(0, nop, 1, 32'hAABBCCDD);
    chk("post_rst_ldbu", obs_wd, 32'h000000CC);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ri = mk($urandom, $urandom, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
      ri.waddr = 5'($urandom);
      cycle(($urandom_range(0, 3) != 0), ri, ($urandom_range(0, 9) < 7), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
